dbus_lsu: RTL

Load/store bus master between the core's MEM stage and the external data bus (DAD/DDT/MREQ/WRITE/SIZE/ACKD_n).
- Accepts one access request per MEM-stage instruction and drives the bus until ACKD_n.
- Stalls the pipeline while the access is outstanding.
- Returns sign/zero-extended load data, a misalignment fault, or a bus timeout error.

---
 rtl/dbus_lsu_pkg.sv | 27 ++
 rtl/dbus_extend.sv | 26 ++
 rtl/dbus_lsu.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/dbus_lsu_pkg.sv
// Shared definitions for the load/store data-bus master: bus size codes,
// FSM state encoding and the alignment rule.
package dbus_lsu_pkg;

    localparam int BIT_WIDTH = 32;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10
    } state_e;

    // Size code 11 is a byte access, which is always aligned.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] addr_lo);
        case (size)
            SZ_WORD: return addr_lo != 2'b00;
            SZ_HALF: return addr_lo[0];
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dbus_extend.sv
// Combinational load-data extension: word passes through, half/byte are
// taken from the low lanes and sign- or zero-extended.
module dbus_extend
    import dbus_lsu_pkg::*;
#(
    parameter int BIT_WIDTH = dbus_lsu_pkg::BIT_WIDTH
) (
    input  logic [1:0]           size,
    input  logic                 is_unsigned,
    input  logic [BIT_WIDTH-1:0] din,
    output logic [BIT_WIDTH-1:0] dout
);

    // NOTE: dout gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        dout = din;
        case (size)
            SZ_WORD: dout = din;
            SZ_HALF: dout = is_unsigned ? BIT_WIDTH'(din[15:0])
                                        : {{(BIT_WIDTH-16){din[15]}}, din[15:0]};
            default: dout = is_unsigned ? BIT_WIDTH'(din[7:0])
                                        : {{(BIT_WIDTH-8){din[7]}}, din[7:0]};
        endcase
    end

endmodule

// File: rtl/dbus_lsu.sv
// Load/store bus master: takes one MEM-stage access, runs the registered bus
// cycle until ACKD_n or timeout, and returns extended data / fault / error.
module dbus_lsu
    import dbus_lsu_pkg::*;
#(
    parameter int BIT_WIDTH = dbus_lsu_pkg::BIT_WIDTH,
    parameter int TIMEOUT   = 255,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 m_req,
    input  logic                 m_we,
    input  logic [1:0]           m_size,
    input  logic                 m_unsigned,
    input  logic [BIT_WIDTH-1:0] m_addr,
    input  logic [BIT_WIDTH-1:0] m_wdata,
    output logic [BIT_WIDTH-1:0] m_rdata,
    output logic                 m_rvalid,
    output logic                 m_stall,
    output logic                 m_fault,
    output logic                 m_buserr,
    output logic [BIT_WIDTH-1:0] DAD,
    inout  wire  [BIT_WIDTH-1:0] DDT,
    output logic                 MREQ,
    output logic                 WRITE,
    output logic [1:0]           SIZE,
    input  logic                 ACKD_n
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    state_e               state_q, state_d;
    logic [BIT_WIDTH-1:0] dad_q, dad_d;
    logic [BIT_WIDTH-1:0] wdata_q, wdata_d;
    logic [BIT_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]           size_q, size_d;
    logic                 write_q, write_d;
    logic                 mreq_q, mreq_d;
    logic                 uns_q, uns_d;
    logic                 fault_q, fault_d;
    logic                 buserr_q, buserr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [1:0]           req_size;
    logic [BIT_WIDTH-1:0] ext_data;

    dbus_extend #(.BIT_WIDTH(BIT_WIDTH)) u_extend (
        .size        (size_q),
        .is_unsigned (uns_q),
        .din         (DDT),
        .dout        (ext_data)
    );

    assign req_size = (m_size == 2'b11) ? SZ_BYTE : m_size;

    always_comb begin
        state_d  = state_q;
        dad_d    = dad_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        size_d   = size_q;
        write_d  = write_q;
        mreq_d   = mreq_q;
        uns_d    = uns_q;
        fault_d  = fault_q;
        buserr_d = buserr_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (m_req) begin
                    if (is_misaligned(req_size, m_addr[1:0])) begin
                        fault_d = 1'b1;
                        rdata_d = '0;
                        state_d = ST_DONE;
                    end else begin
                        dad_d   = m_addr;
                        size_d  = req_size;
                        write_d = m_we;
                        uns_d   = m_unsigned;
                        mreq_d  = 1'b1;
                        cnt_d   = '0;
                        // Store data is right-justified with unused upper lanes zeroed.
                        case (req_size)
                            SZ_WORD: wdata_d = m_wdata;
                            SZ_HALF: wdata_d = BIT_WIDTH'(m_wdata[15:0]);
                            default: wdata_d = BIT_WIDTH'(m_wdata[7:0]);
                        endcase
                        state_d = ST_ACCESS;
                    end
                end
            end
            ST_ACCESS: begin
                // An ack wins over a timeout reached on the same edge.
                if (!ACKD_n) begin
                    rdata_d = ext_data;
                    mreq_d  = 1'b0;
                    write_d = 1'b0;
                    state_d = ST_DONE;
                end else if (cnt_q == TIMEOUT_C) begin
                    rdata_d  = '0;
                    buserr_d = 1'b1;
                    mreq_d   = 1'b0;
                    write_d  = 1'b0;
                    state_d  = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                fault_d  = 1'b0;
                buserr_d = 1'b0;
                cnt_d    = '0;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            dad_q    <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            size_q   <= SZ_WORD;
            write_q  <= 1'b0;
            mreq_q   <= 1'b0;
            uns_q    <= 1'b0;
            fault_q  <= 1'b0;
            buserr_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            dad_q    <= dad_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            size_q   <= size_d;
            write_q  <= write_d;
            mreq_q   <= mreq_d;
            uns_q    <= uns_d;
            fault_q  <= fault_d;
            buserr_q <= buserr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign DDT      = (mreq_q && write_q) ? wdata_q : {BIT_WIDTH{1'bz}};
    assign DAD      = dad_q;
    assign MREQ     = mreq_q;
    assign WRITE    = write_q;
    assign SIZE     = size_q;
    assign m_rdata  = rdata_q;
    assign m_rvalid = (state_q == ST_DONE);
    assign m_fault  = fault_q;
    assign m_buserr = buserr_q;
    assign m_stall  = ((state_q == ST_IDLE) && m_req) || (state_q == ST_ACCESS);

endmodule
